uart_rx_display_ctrl: RTL and testbench

//  Readout controller between the UART RX FIFO and the two-digit hex display.
//  - Synchronises and debounces the display_next button.
//  - Issues exactly one FIFO pop per accepted press and latches the popped byte into the msd/lsd digits.
//  - Keeps a sticky error flag from the RX framer and holds the receiver while an error is pending.

---
 rtl/uart_rx_display_ctrl.sv | 139 +++++++++++++
 tb/tb_uart_rx_display_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_display_ctrl.sv
// Readout controller between the UART RX FIFO and the two-digit hex display.
// Debounced button press -> single FIFO pop -> latch byte into msd/lsd; sticky RX error.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for an accepted press
// POP    | fifo_rd_en high for exactly this cycle
// WAIT   | counting down RD_LATENCY cycles, latch read data on last
module uart_rx_display_ctrl #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int RD_LATENCY      = 1
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       display_next,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    input  logic       rx_error,
    output logic       fifo_rd_en,
    output logic [3:0] data_out_msd,
    output logic [3:0] data_out_lsd,
    output logic       error,
    output logic       rx_hold,
    output logic       underflow
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WT_W-1:0] WT_LOAD = WT_W'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_WAIT
    } state_t;

    state_t state, state_nxt;

    logic            sync1, sync2;
    logic            stable;
    logic [DB_W-1:0] db_cnt;
    logic            press;
    logic [WT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            underflow_nxt;
    logic            latch;

    always_ff @(posedge CLK) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= display_next;
            sync2 <= sync1;
        end
    end

    // Any cycle where the synchronised level agrees with the stable level restarts the count.
    always_ff @(posedge CLK) begin
        if (reset) begin
            stable <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= ~stable;
                db_cnt <= '0;
                press  <= ~stable;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            underflow    <= 1'b0;
            data_out_msd <= 4'h0;
            data_out_lsd <= 4'h0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            underflow <= underflow_nxt;
            if (latch) begin
                data_out_msd <= fifo_rd_data[7:4];
                data_out_lsd <= fifo_rd_data[3:0];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        underflow_nxt = 1'b0;
        latch         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (press) begin
                    if (fifo_empty) begin
                        underflow_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_POP;
                    end
                end
            end
            ST_POP: begin
                state_nxt    = ST_WAIT;
                wait_cnt_nxt = WT_LOAD;
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    latch     = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - WT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign fifo_rd_en = (state == ST_POP);

    always_ff @(posedge CLK) begin
        if (reset) begin
            error <= 1'b0;
        end else if (rx_error) begin
            error <= 1'b1;
        end
    end

    assign rx_hold = error;

endmodule

// File: tb/tb_uart_rx_display_ctrl.sv
// Self-checking bench for uart_rx_display_ctrl: directed scenarios plus randomized
// button/FIFO/error traffic compared every cycle against a behavioural model.
module tb_uart_rx_display_ctrl;

    localparam int D = 8;
    localparam int R = 1;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       display_next = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       rx_error = 1'b0;
    logic       fifo_rd_en;
    logic [3:0] data_out_msd;
    logic [3:0] data_out_lsd;
    logic       error;
    logic       rx_hold;
    logic       underflow;

    uart_rx_display_ctrl #(.DEBOUNCE_CYCLES(D), .RD_LATENCY(R)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .display_next (display_next),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .rx_error     (rx_error),
        .fifo_rd_en   (fifo_rd_en),
        .data_out_msd (data_out_msd),
        .data_out_lsd (data_out_lsd),
        .error        (error),
        .rx_hold      (rx_hold),
        .underflow    (underflow)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    int uf_cnt   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail < 50)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // FIFO stand-in: pops on fifo_rd_en, data valid the following cycle
    logic [7:0] fifo_q[$];
    always @(posedge CLK) begin
        if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Behavioural model
    logic       m_valid = 1'b0;
    logic       m_s1 = 1'b0, m_s2 = 1'b0, m_stable = 1'b0, m_press = 1'b0;
    int         m_run = 0, m_remain = 0;
    logic [7:0] m_pending = 8'h00, m_digits = 8'h00;
    logic       m_err = 1'b0, m_uf = 1'b0, m_rden = 1'b0;
    logic [7:0] m_q[$];

    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (reset) begin
            m_valid  = 1'b1;
            m_s1 = 1'b0; m_s2 = 1'b0; m_stable = 1'b0; m_press = 1'b0;
            m_run = 0; m_remain = 0;
            m_digits = 8'h00; m_err = 1'b0; m_uf = 1'b0; m_rden = 1'b0;
        end else begin
            m_err  = m_err | rx_error;
            m_uf   = 1'b0;
            m_rden = 1'b0;
            if (m_remain > 0) begin
                m_remain--;
                if (m_remain == 0) m_digits = m_pending;
            end else if (m_press) begin
                if (fifo_empty) begin
                    m_uf = 1'b1;
                end else begin
                    m_rden   = 1'b1;
                    m_remain = R + 1;
                    m_pending = 8'h00;
                    if (m_q.size() > 0) m_pending = m_q.pop_front();
                end
            end
            m_press = 1'b0;
            if (m_s2 != m_stable) begin
                m_run++;
                if (m_run == D) begin
                    m_stable = m_s2;
                    m_run    = 0;
                    m_press  = m_s2;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = display_next;
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("fifo_rd_en", int'(fifo_rd_en), int'(m_rden));
            chk("digits", int'({data_out_msd, data_out_lsd}), int'(m_digits));
            chk("error", int'(error), int'(m_err));
            chk("rx_hold", int'(rx_hold), int'(m_err));
            chk("underflow", int'(underflow), int'(m_uf));
            if (fifo_rd_en) rd_cnt++;
            if (underflow) uf_cnt++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        m_q.push_back(b);
    endtask

    task automatic press(input int len);
        display_next = 1'b1;
        cycles(len);
        display_next = 1'b0;
    endtask

    function automatic int digits();
        return int'({data_out_msd, data_out_lsd});
    endfunction

    int rd0, uf0, e0, prev_digits;

    initial begin
        // 1: reset after an error, clears everything
        @(negedge CLK);
        rx_error = 1'b1;
        cycles(3);
        rx_error = 1'b0;
        reset    = 1'b1;
        cycles(1);
        chk("t1_error", int'(error), 0);
        chk("t1_digits", digits(), 0);
        chk("t1_rd_en", int'(fifo_rd_en), 0);
        chk("t1_underflow", int'(underflow), 0);
        cycles(19);
        reset = 1'b0;
        cycles(20);

        // 2: single press pops A5, digits update on edge D+R+3
        push_byte(8'hA5);
        cycles(3);
        rd0 = rd_cnt;
        display_next = 1'b1;
        e0 = cyc + 1;
        cycles(12);
        chk("t2_edge_index", cyc, e0 + 11);
        chk("t2_before_latch", digits(), 8'h00);
        cycles(1);
        chk("t2_after_latch", digits(), 8'hA5);
        display_next = 1'b0;
        cycles(25);
        chk("t2_pop_count", rd_cnt - rd0, 1);

        // 3: short glitch ignored
        rd0 = rd_cnt; uf0 = uf_cnt;
        press(5);
        cycles(25);
        chk("t3_pops", rd_cnt - rd0, 0);
        chk("t3_underflow", uf_cnt - uf0, 0);
        chk("t3_digits", digits(), 8'hA5);

        // 4: press on empty FIFO
        rd0 = rd_cnt; uf0 = uf_cnt;
        press(13);
        cycles(25);
        chk("t4_underflow", uf_cnt - uf0, 1);
        chk("t4_pops", rd_cnt - rd0, 0);
        chk("t4_digits", digits(), 8'hA5);

        // 5: sticky error, pops still allowed
        rx_error = 1'b1;
        cycles(1);
        rx_error = 1'b0;
        cycles(1000);
        chk("t5_error_held", int'(error), 1);
        chk("t5_hold_held", int'(rx_hold), 1);
        push_byte(8'h0F);
        cycles(3);
        press(13);
        cycles(20);
        chk("t5_digits", digits(), 8'h0F);
        chk("t5_error_after_pop", int'(error), 1);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(10);

        // 6: sixteen presses read bytes in order
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        cycles(3);
        rd0 = rd_cnt;
        for (int i = 0; i < 16; i++) begin
            press(13);
            cycles(20);
            chk("t6_digit_seq", digits(), i);
        end
        chk("t6_pop_count", rd_cnt - rd0, 16);
        chk("t6_fifo_drained", int'(fifo_q.size()), 0);

        // reset while in WAIT: no latch of the in-flight byte
        push_byte(8'h77);
        cycles(3);
        display_next = 1'b1;
        cycles(12);
        reset = 1'b1;
        display_next = 1'b0;
        cycles(1);
        chk("t6_rst_wait_digits", digits(), 0);
        chk("t6_rst_wait_rd_en", int'(fifo_rd_en), 0);
        cycles(2);
        reset = 1'b0;
        cycles(20);
        chk("t6_rst_wait_after", digits(), 0);

        // randomized traffic against the model
        for (int it = 0; it < 80; it++) begin
            int act;
            act = int'($urandom_range(0, 9));
            case (act)
                0, 1: begin
                    int n;
                    n = int'($urandom_range(1, 3));
                    for (int k = 0; k < n; k++) push_byte(8'($urandom));
                end
                2, 3, 4, 5: press(int'($urandom_range(6, 16)));
                6: press(int'($urandom_range(1, 7)));
                7: begin
                    rx_error = 1'b1;
                    cycles(1);
                    rx_error = 1'b0;
                end
                8: begin
                    reset = 1'b1;
                    cycles(int'($urandom_range(1, 3)));
                    reset = 1'b0;
                end
                default: ;
            endcase
            cycles(int'($urandom_range(2, 25)));
        end
        cycles(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
